mem_bist_master: RTL
====================

# mem_bist_master

Upstream traffic generator for the handshaked single-port memory. When triggered, it writes a deterministic pattern to every address through the memory's valid/ready request port, then reads every address back and compares the data. It reports pass/fail, the first failing address, a saturating error count and a handshake timeout, and is used for power-on self-test and bring-up.

## Interface
- DEPTH, 64, number of memory words addressed
- WIDTH, 4, data width in bits
- ADDR_WIDTH, $clog2(DEPTH), address width
- SEED, 0, pattern offset; must fit in WIDTH bits
- TIMEOUT, 16, maximum cycles `valid_o` may wait for `ready_i`; must be ≥ 1
- clk_i  input  1  single clock; all logic on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- start_i  input  1  level trigger; sampled only in IDLE
- valid_o  output  1  request valid to memory
- wr_rd_en_o  output  1  1 = write, 0 = read
- addr_o  output  ADDR_WIDTH  request address
- w_data_o  output  WIDTH  write data
- ready_i  input  1  memory accepts request
- rdata_i  input  WIDTH  read data, valid the cycle after a read handshake
- busy_o  output  1  test in progress
- done_o  output  1  test finished; held until `start_i` is low
- fail_o  output  1  any mismatch or timeout; valid while `done_o` = 1
- timeout_o  output  1  ready wait exceeded TIMEOUT
- err_addr_o  output  ADDR_WIDTH  address of the first mismatch
- err_cnt_o  output  8  mismatch count, saturates at 255

## Operation
- **Pattern.** `pat(a) = (a + SEED) mod 2^WIDTH`, where `a` is zero-extended or truncated to WIDTH.
- **IDLE.**
  - `start_i` = 1 → WRITE, with `addr` = 0.
  - On that transition, clear `fail_o`, `timeout_o`, `err_addr_o` and `err_cnt_o`.
- **WRITE.**
  - Drive `valid_o` = 1, `wr_rd_en_o` = 1, `addr_o` = addr, `w_data_o` = pat(addr).
  - A handshake is `valid_o && ready_i` at a clock edge.
  - On handshake: if addr = DEPTH-1 → READ with addr = 0; otherwise addr + 1 and stay in WRITE.
- **READ.**
  - Drive `valid_o` = 1, `wr_rd_en_o` = 0, `addr_o` = addr.
  - On handshake → RDATA.
- **RDATA.**
  - `valid_o` = 0.
  - Sample `rdata_i` and compare it against pat(addr).
  - On mismatch: if `err_cnt_o` = 0, set `err_addr_o` = addr; then `err_cnt_o` saturating +1, `fail_o` = 1.
  - If addr = DEPTH-1 → DONE; otherwise addr + 1 → READ.
- **DONE.**
  - `done_o` = 1, `busy_o` = 0, `valid_o` = 0.
  - `start_i` = 0 → IDLE. Result outputs hold until the next start.
- **Timeout.**
  - A wait counter increments on each cycle with `valid_o` = 1 and `ready_i` = 0, and clears on every handshake.
  - When the counter reaches TIMEOUT: `timeout_o` = 1, `fail_o` = 1, go to DONE immediately.
- **Request hold.** While `valid_o` = 1 and there has been no handshake, `addr_o`, `w_data_o` and `wr_rd_en_o` stay stable.
- **Start while busy.** `start_i` is ignored outside IDLE.
- **Unused outputs.** `w_data_o` = 0 whenever `wr_rd_en_o` = 0 or `valid_o` = 0.

## Timing
- **Reset values.** All outputs are 0; state = IDLE.
- **Mid-test reset.** Reset asserted during a test aborts it immediately; no partial result is retained.
- **Start latency.** `valid_o` rises on the edge after `start_i` is sampled high in IDLE.
- **Outputs.** All outputs are registered; none depend combinationally on `ready_i`.
- **Back-to-back writes.** One write per cycle when `ready_i` is held high.
- **Reads.** Each read costs handshake + 1 RDATA cycle, so 2 cycles minimum.
- **Test duration.**
  - Minimum total with ideal ready: DEPTH + 2·DEPTH + 1 cycles from start to `done_o`.
  - With a memory that raises ready one cycle after valid, every request takes 2 cycles.
- **Read data capture.** `rdata_i` is sampled exactly one cycle after the read handshake edge, matching the memory's read latency.

## Configuration
- `MEM_BIST_INV_PASS_EN`
  - **Defined:** after the first read pass, a second write pass and read pass run using the inverted pattern `~pat(a)`.
    - The mismatch rules and `err_addr_o` / `err_cnt_o` accumulate across both passes.
    - DONE follows the second read of DEPTH-1.
  - **Undefined:** single write/read pass only; the inverted-pass states are not compiled in.

## Test plan
- **Reset:** assert `rst_i` = 0 with random inputs → every output is 0. After release with `start_i` = 0, outputs stay 0.
- **Ideal memory, defaults** (ready one cycle after valid, SEED = 3):
  - Pulse `start_i`.
  - Required: 64 writes with `w_data_o` = (addr+3) & 4'hF, then 64 reads.
  - Result: `done_o` = 1, `fail_o` = 0, `err_cnt_o` = 0.
- **Fault injection:** memory returns 4'h0 at addrs 10 and 40 (expected 4'hD and 4'hB) → `fail_o` = 1, `err_addr_o` = 10, `err_cnt_o` = 2, `timeout_o` = 0.
- **Timeout:** `ready_i` tied to 0 → after 16 cycles of `valid_o` at addr 0:
  - `timeout_o` = 1, `fail_o` = 1, `done_o` = 1.
  - `valid_o` falls the same cycle `done_o` rises.
- **Reset mid-test and start while busy:**
  - Reset asserted during the write to addr 20 → all outputs 0.
  - A new start restarts at addr 0 with a write.
  - A `start_i` toggle while busy has no effect.
- **`MEM_BIST_INV_PASS_EN` defined, ideal memory:**
  - 256 handshakes total.
  - Second-pass write at addr 0 carries 4'hC.
  - Result: `done_o` = 1, `fail_o` = 0.

Source files
------------

// File: rtl/mem_bist_master.sv
// Memory BIST master: writes pat(a) = a + SEED to every address, reads each word back and compares.
// Optional `MEM_BIST_INV_PASS_EN adds a second write/read pass that uses the inverted pattern.
module mem_bist_master #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SEED       = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      w_data_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [7:0]            err_cnt_o
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDATA, DONE} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [WAIT_W-1:0]     wait_cnt, wait_n;
  logic                  fail_n, timeout_n;
  logic [ADDR_WIDTH-1:0] err_addr_n;
  logic [7:0]            err_cnt_n;
  logic                  hs, req;
  logic                  valid_n, wr_n, busy_n, done_n;
  logic [ADDR_WIDTH-1:0] addr_o_n;
  logic [WIDTH-1:0]      w_data_n;

`ifdef MEM_BIST_INV_PASS_EN
  logic pass, pass_n;
`else
  logic pass;
  assign pass = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a, input logic inv);
    logic [WIDTH+ADDR_WIDTH-1:0] a_ext;
    logic [WIDTH-1:0]            p;
    a_ext = {{WIDTH{1'b0}}, a};
    p     = a_ext[WIDTH-1:0] + SEED[WIDTH-1:0];
    return inv ? ~p : p;
  endfunction

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    wait_n     = wait_cnt;
    fail_n     = fail_o;
    timeout_n  = timeout_o;
    err_addr_n = err_addr_o;
    err_cnt_n  = err_cnt_o;
`ifdef MEM_BIST_INV_PASS_EN
    pass_n     = pass;
`endif
    req = (state == WRITE) || (state == READ);
    hs  = valid_o && ready_i;
    case (state)
      IDLE: if (start_i) begin
        state_n    = WRITE;
        addr_n     = '0;
        wait_n     = '0;
        fail_n     = 1'b0;
        timeout_n  = 1'b0;
        err_addr_n = '0;
        err_cnt_n  = '0;
`ifdef MEM_BIST_INV_PASS_EN
        pass_n     = 1'b0;
`endif
      end
      WRITE: if (hs) begin
        wait_n = '0;
        if (addr == LAST) begin
          state_n = READ;
          addr_n  = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      READ: if (hs) begin
        wait_n  = '0;
        state_n = RDATA;
      end
      RDATA: begin
        // rdata_i belongs to the read handshaken on the previous edge
        if (rdata_i != pat(addr, pass)) begin
          if (err_cnt_o == 8'd0) err_addr_n = addr;
          if (err_cnt_o != 8'hFF) err_cnt_n = err_cnt_o + 8'd1;
          fail_n = 1'b1;
        end
        if (addr == LAST) begin
          addr_n  = '0;
`ifdef MEM_BIST_INV_PASS_EN
          if (!pass) begin
            pass_n  = 1'b1;
            state_n = WRITE;
          end else begin
            state_n = DONE;
          end
`else
          state_n = DONE;
`endif
        end else begin
          addr_n  = addr + 1'b1;
          state_n = READ;
        end
      end
      DONE: if (!start_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (req && !ready_i) begin
      if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
        timeout_n = 1'b1;
        fail_n    = 1'b1;
        state_n   = DONE;
      end else begin
        wait_n = wait_cnt + 1'b1;
      end
    end

    // Request outputs are registered from the next state so nothing depends on ready_i combinationally
    valid_n  = (state_n == WRITE) || (state_n == READ);
    wr_n     = (state_n == WRITE);
    busy_n   = valid_n || (state_n == RDATA);
    done_n   = (state_n == DONE);
    addr_o_n = valid_n ? addr_n : '0;
`ifdef MEM_BIST_INV_PASS_EN
    w_data_n = wr_n ? pat(addr_n, pass_n) : '0;
`else
    w_data_n = wr_n ? pat(addr_n, 1'b0) : '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      addr       <= '0;
      wait_cnt   <= '0;
      valid_o    <= 1'b0;
      wr_rd_en_o <= 1'b0;
      addr_o     <= '0;
      w_data_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      timeout_o  <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
`ifdef MEM_BIST_INV_PASS_EN
      pass       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      wait_cnt   <= wait_n;
      valid_o    <= valid_n;
      wr_rd_en_o <= wr_n;
      addr_o     <= addr_o_n;
      w_data_o   <= w_data_n;
      busy_o     <= busy_n;
      done_o     <= done_n;
      fail_o     <= fail_n;
      timeout_o  <= timeout_n;
      err_addr_o <= err_addr_n;
      err_cnt_o  <= err_cnt_n;
`ifdef MEM_BIST_INV_PASS_EN
      pass       <= pass_n;
`endif
    end
  end
endmodule
